// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and EX-branch flush control.
// Also keeps saturating stall and flush event counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_ALUSrc1,
    input  logic             ID_ALUSrc2,
    input  logic             ID_Sign,
    input  logic             ID_BranchType,
    input  logic             ID_JumpType,
    input  logic [1:0]       ID_RegDst,
    input  logic [1:0]       ID_MemtoReg,
    input  logic [5:0]       ID_ALUFun,
    input  logic [31:0]      ID_PCplus4,
    input  logic [31:0]      ID_RsData,
    input  logic [31:0]      ID_RtData,
    input  logic [31:0]      ID_Imm,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic [4:0]       ID_Rd,
    input  logic [4:0]       ID_Shamt,
    input  logic             EX_ALUOut0,
    output logic             EX_RegWrite,
    output logic             EX_MemRead,
    output logic             EX_MemWrite,
    output logic             EX_ALUSrc1,
    output logic             EX_ALUSrc2,
    output logic             EX_Sign,
    output logic             EX_BranchType,
    output logic [1:0]       EX_RegDst,
    output logic [1:0]       EX_MemtoReg,
    output logic [5:0]       EX_ALUFun,
    output logic [31:0]      EX_PCplus4,
    output logic [31:0]      EX_RsData,
    output logic [31:0]      EX_RtData,
    output logic [31:0]      EX_Imm,
    output logic [4:0]       EX_Rs,
    output logic [4:0]       EX_Rt,
    output logic [4:0]       EX_Rd,
    output logic [4:0]       EX_Shamt,
    output logic             EX_Valid,
    output logic [4:0]       EX_WriteAddr,
    output logic             BranchTaken,
    output logic             Stall,
    output logic             FlushIFID,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        aluSrc1;
        logic        aluSrc2;
        logic        sign;
        logic        branchType;
        logic [1:0]  regDst;
        logic [1:0]  memtoReg;
        logic [5:0]  aluFun;
        logic [31:0] pcPlus4;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic        valid;
    } exBundle_t;

    exBundle_t exReg;
    exBundle_t exNext;
    logic      loadUse;

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        EX_WriteAddr = exReg.rt;
        unique case (exReg.regDst)
            2'b00: EX_WriteAddr = exReg.rt;
            2'b01: EX_WriteAddr = exReg.rd;
            2'b10: EX_WriteAddr = 5'd31;
            2'b11: EX_WriteAddr = 5'd26;
        endcase
    end

    // Rs and Rt are always compared, even for formats that ignore Rt.
    assign loadUse     = exReg.valid & exReg.memRead & exReg.regWrite
                       & (EX_WriteAddr != 5'd0)
                       & ((EX_WriteAddr == ID_Rs) | (EX_WriteAddr == ID_Rt));
    assign BranchTaken = exReg.valid & exReg.branchType & EX_ALUOut0;
    assign Stall       = loadUse & ~BranchTaken;
    assign FlushIFID   = BranchTaken | (ID_JumpType & ~loadUse);

    // Anything other than a clean capture leaves exNext as an all-zero bubble.
    always_comb begin
        exNext = '0;
        if (!BranchTaken && !loadUse) begin
            exNext.regWrite   = ID_RegWrite;
            exNext.memRead    = ID_MemRead;
            exNext.memWrite   = ID_MemWrite;
            exNext.aluSrc1    = ID_ALUSrc1;
            exNext.aluSrc2    = ID_ALUSrc2;
            exNext.sign       = ID_Sign;
            exNext.branchType = ID_BranchType;
            exNext.regDst     = ID_RegDst;
            exNext.memtoReg   = ID_MemtoReg;
            exNext.aluFun     = ID_ALUFun;
            exNext.pcPlus4    = ID_PCplus4;
            exNext.rsData     = ID_RsData;
            exNext.rtData     = ID_RtData;
            exNext.imm        = ID_Imm;
            exNext.rs         = ID_Rs;
            exNext.rt         = ID_Rt;
            exNext.rd         = ID_Rd;
            exNext.shamt      = ID_Shamt;
            exNext.valid      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exReg    <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            exReg <= exNext;
            if (Stall && (StallCnt != '1))
                StallCnt <= StallCnt + 1'b1;
            if (BranchTaken && (FlushCnt != '1))
                FlushCnt <= FlushCnt + 1'b1;
        end
    end

    assign EX_RegWrite   = exReg.regWrite;
    assign EX_MemRead    = exReg.memRead;
    assign EX_MemWrite   = exReg.memWrite;
    assign EX_ALUSrc1    = exReg.aluSrc1;
    assign EX_ALUSrc2    = exReg.aluSrc2;
    assign EX_Sign       = exReg.sign;
    assign EX_BranchType = exReg.branchType;
    assign EX_RegDst     = exReg.regDst;
    assign EX_MemtoReg   = exReg.memtoReg;
    assign EX_ALUFun     = exReg.aluFun;
    assign EX_PCplus4    = exReg.pcPlus4;
    assign EX_RsData     = exReg.rsData;
    assign EX_RtData     = exReg.rtData;
    assign EX_Imm        = exReg.imm;
    assign EX_Rs         = exReg.rs;
    assign EX_Rt         = exReg.rt;
    assign EX_Rd         = exReg.rd;
    assign EX_Shamt      = exReg.shamt;
    assign EX_Valid      = exReg.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: capture, load-use stall, branch flush,
// collisions, reset, and counter saturation (narrow counters keep the run short).
module tb_id_ex_stage;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    logic ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc1, ID_ALUSrc2;
    logic ID_Sign, ID_BranchType, ID_JumpType;
    logic [1:0]  ID_RegDst, ID_MemtoReg;
    logic [5:0]  ID_ALUFun;
    logic [31:0] ID_PCplus4, ID_RsData, ID_RtData, ID_Imm;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
    logic        EX_ALUOut0;
    logic EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc1, EX_ALUSrc2;
    logic EX_Sign, EX_BranchType;
    logic [1:0]  EX_RegDst, EX_MemtoReg;
    logic [5:0]  EX_ALUFun;
    logic [31:0] EX_PCplus4, EX_RsData, EX_RtData, EX_Imm;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
    logic        EX_Valid;
    logic [4:0]  EX_WriteAddr;
    logic        BranchTaken, Stall, FlushIFID;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int vecCnt = 0;
    int errCnt = 0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2), .ID_Sign(ID_Sign),
        .ID_BranchType(ID_BranchType), .ID_JumpType(ID_JumpType),
        .ID_RegDst(ID_RegDst), .ID_MemtoReg(ID_MemtoReg), .ID_ALUFun(ID_ALUFun),
        .ID_PCplus4(ID_PCplus4), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
        .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_Shamt(ID_Shamt), .EX_ALUOut0(EX_ALUOut0),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_ALUSrc1(EX_ALUSrc1), .EX_ALUSrc2(EX_ALUSrc2), .EX_Sign(EX_Sign),
        .EX_BranchType(EX_BranchType), .EX_RegDst(EX_RegDst),
        .EX_MemtoReg(EX_MemtoReg), .EX_ALUFun(EX_ALUFun),
        .EX_PCplus4(EX_PCplus4), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
        .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_Shamt(EX_Shamt), .EX_Valid(EX_Valid), .EX_WriteAddr(EX_WriteAddr),
        .BranchTaken(BranchTaken), .Stall(Stall), .FlushIFID(FlushIFID),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearId();
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc1, ID_ALUSrc2} = '0;
        {ID_Sign, ID_BranchType, ID_JumpType} = '0;
        ID_RegDst = '0; ID_MemtoReg = '0; ID_ALUFun = '0;
        ID_PCplus4 = '0; ID_RsData = '0; ID_RtData = '0; ID_Imm = '0;
        ID_Rs = '0; ID_Rt = '0; ID_Rd = '0; ID_Shamt = '0;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic presentLoad(input logic [4:0] rs, input logic [4:0] rt);
        clearId();
        ID_RegWrite = 1'b1; ID_MemRead = 1'b1; ID_MemtoReg = 2'b01;
        ID_ALUSrc2 = 1'b1; ID_Rs = rs; ID_Rt = rt; ID_RegDst = 2'b00;
    endtask

    task automatic presentAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clearId();
        ID_RegWrite = 1'b1; ID_RegDst = 2'b01; ID_ALUFun = 6'h01;
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    endtask

    initial begin
        int seenStalls;
        clearId();
        EX_ALUOut0 = 1'b0;
        reset = 1'b0;

        // Reset held with random ID activity.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_BranchType} = 4'($urandom);
            ID_PCplus4 = $urandom; ID_Rs = 5'($urandom); ID_Rt = 5'($urandom);
            ID_RegDst = 2'($urandom); EX_ALUOut0 = 1'($urandom);
        end
        ID_JumpType = 1'b1;
        #1;
        check("rst_valid", 32'(EX_Valid), 32'd0);
        check("rst_regwrite", 32'(EX_RegWrite), 32'd0);
        check("rst_pc", EX_PCplus4, 32'd0);
        check("rst_stallcnt", 32'(StallCnt), 32'd0);
        check("rst_flushcnt", 32'(FlushCnt), 32'd0);
        check("rst_branch", 32'(BranchTaken), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_flush_jump", 32'(FlushIFID), 32'd1);

        // Release, then an add must appear in EX one edge later.
        @(negedge clk);
        reset = 1'b1;
        EX_ALUOut0 = 1'b0;
        presentAdd(5'd1, 5'd2, 5'd8);
        ID_PCplus4 = 32'h0000_0100; ID_RsData = 32'hdead_beef;
        tick();
        check("add_valid", 32'(EX_Valid), 32'd1);
        check("add_waddr", 32'(EX_WriteAddr), 32'd8);
        check("add_pc", EX_PCplus4, 32'h100);
        check("add_rsdata", EX_RsData, 32'hdead_beef);
        check("add_alufun", 32'(EX_ALUFun), 32'h01);

        // RegDst 10 and 11 map to fixed registers.
        clearId(); ID_RegWrite = 1'b1; ID_RegDst = 2'b10; ID_Rt = 5'd3; ID_Rd = 5'd4;
        tick();
        check("waddr_31", 32'(EX_WriteAddr), 32'd31);
        ID_RegDst = 2'b11;
        tick();
        check("waddr_26", 32'(EX_WriteAddr), 32'd26);

        // Load-use: lw $9 then add using $9; jump in ID must not flush while stalled.
        presentLoad(5'd3, 5'd9);
        tick();
        presentAdd(5'd9, 5'd10, 5'd11);
        ID_JumpType = 1'b1;
        #1;
        check("lu_stall", 32'(Stall), 32'd1);
        check("lu_noflush", 32'(FlushIFID), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(EX_Valid), 32'd0);
        check("lu_bubble_rw", 32'(EX_RegWrite), 32'd0);
        check("lu_stall_drop", 32'(Stall), 32'd0);
        check("lu_jump_flush", 32'(FlushIFID), 32'd1);
        check("lu_stallcnt", 32'(StallCnt), 32'd1);
        ID_JumpType = 1'b0;
        tick();
        check("lu_add_valid", 32'(EX_Valid), 32'd1);
        check("lu_add_waddr", 32'(EX_WriteAddr), 32'd11);
        check("lu_stallcnt_hold", 32'(StallCnt), 32'd1);

        // Load to $zero never stalls.
        presentLoad(5'd3, 5'd0);
        tick();
        presentAdd(5'd0, 5'd5, 5'd6);
        #1;
        check("zero_stall", 32'(Stall), 32'd0);
        tick();
        check("zero_valid", 32'(EX_Valid), 32'd1);
        check("zero_waddr", 32'(EX_WriteAddr), 32'd6);

        // Taken branch flushes and bubbles.
        clearId(); ID_BranchType = 1'b1; ID_Rs = 5'd4; ID_Rt = 5'd5;
        tick();
        presentAdd(5'd1, 5'd2, 5'd12);
        EX_ALUOut0 = 1'b1;
        #1;
        check("br_taken", 32'(BranchTaken), 32'd1);
        check("br_flush", 32'(FlushIFID), 32'd1);
        tick();
        EX_ALUOut0 = 1'b0;
        check("br_bubble", 32'(EX_Valid), 32'd0);
        check("br_flushcnt", 32'(FlushCnt), 32'd1);

        // Not-taken branch: normal capture.
        clearId(); ID_BranchType = 1'b1;
        tick();
        presentAdd(5'd1, 5'd2, 5'd12);
        #1;
        check("bnt_taken", 32'(BranchTaken), 32'd0);
        check("bnt_flush", 32'(FlushIFID), 32'd0);
        tick();
        check("bnt_valid", 32'(EX_Valid), 32'd1);
        check("bnt_waddr", 32'(EX_WriteAddr), 32'd12);
        check("bnt_flushcnt", 32'(FlushCnt), 32'd1);

        // Collision: taken branch while a load-use condition is visible.
        presentLoad(5'd3, 5'd9);
        ID_BranchType = 1'b1;
        tick();
        presentAdd(5'd9, 5'd1, 5'd2);
        EX_ALUOut0 = 1'b1;
        #1;
        check("col_stall", 32'(Stall), 32'd0);
        check("col_flush", 32'(FlushIFID), 32'd1);
        tick();
        EX_ALUOut0 = 1'b0;
        check("col_bubble", 32'(EX_Valid), 32'd0);
        check("col_stallcnt", 32'(StallCnt), 32'd1);
        check("col_flushcnt", 32'(FlushCnt), 32'd2);

        // Saturation: lw $9 that reads $9 stalls every other cycle.
        presentLoad(5'd9, 5'd9);
        seenStalls = 0;
        for (int i = 0; i < 2 * ((1 << CNT_W) + 3) + 2; i++) begin
            if (Stall) seenStalls++;
            tick();
        end
        check("sat_events", 32'(seenStalls >= (1 << CNT_W) + 3), 32'd1);
        check("sat_stallcnt", 32'(StallCnt), 32'((1 << CNT_W) - 1));
        for (int i = 0; i < 4; i++) tick();
        check("sat_hold", 32'(StallCnt), 32'((1 << CNT_W) - 1));
        check("sat_flushcnt", 32'(FlushCnt), 32'd2);

        // Reset asserted mid-stall clears everything at once.
        if (!Stall) tick();
        check("mid_pre_stall", 32'(Stall), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_stall", 32'(Stall), 32'd0);
        check("mid_valid", 32'(EX_Valid), 32'd0);
        check("mid_stallcnt", 32'(StallCnt), 32'd0);
        check("mid_flushcnt", 32'(FlushCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
